dual_fetch_unit: RTL

DUAL_FETCH_UNIT -- requirements
Module: dual_fetch_unit

---
 rtl/dual_fetch_unit_if.sv | 22 ++
 rtl/dual_fetch_unit.sv | 135 +++++++++++++
 2 files changed

// File: rtl/dual_fetch_unit_if.sv
// Two-slot instruction memory read port shared by the fetch unit
// and the instruction store.
interface dual_fetch_unit_if;
  logic [11:0] imem_addr_top;
  logic [11:0] imem_addr_bot;
  logic [31:0] imem_data_top;
  logic [31:0] imem_data_bot;

  modport master (
    output imem_addr_top,
    output imem_addr_bot,
    input  imem_data_top,
    input  imem_data_bot
  );

  modport slave (
    input  imem_addr_top,
    input  imem_addr_bot,
    output imem_data_top,
    output imem_data_bot
  );
endinterface

// File: rtl/dual_fetch_unit.sv
// Dual-issue fetch stage: PC plus a two-slot FD latch.
// Define FETCH_PERF_EN to add saturating issue/flush counters.
module dual_fetch_unit (
  input  logic               clock,
  input  logic               reset,
  dual_fetch_unit_if.master  imem,
  input  logic               stall_all,
  input  logic               stall_bot,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_pc,
  input  logic               mispredict,
  input  logic [31:0]        mispredict_pc,
  output logic [31:0]        fd_instr_top,
  output logic [31:0]        fd_instr_bot,
  output logic [31:0]        fd_pc_top,
  output logic [31:0]        fd_pc_bot,
`ifdef FETCH_PERF_EN
  output logic [31:0]        perf_issued,
  output logic [31:0]        perf_flushes,
`endif
  output logic [31:0]        pc
);

  localparam logic [31:0] NOP = 32'h0;

  logic [31:0] pc_q, pc_d, pc_p1;
  logic [31:0] it_top_q, it_top_d;
  logic [31:0] it_bot_q, it_bot_d;
  logic [31:0] pc_top_q, pc_top_d;
  logic [31:0] pc_bot_q, pc_bot_d;
  logic        do_mp, do_rd, do_sb, do_nm;

  assign pc_p1 = pc_q + 32'd1;

  assign imem.imem_addr_top = pc_q[11:0];
  assign imem.imem_addr_bot = pc_p1[11:0];

  assign do_mp = mispredict;
  assign do_rd = !mispredict && !stall_all
               && redirect_valid;
  assign do_sb = !mispredict && !stall_all
               && !redirect_valid && stall_bot;
  assign do_nm = !mispredict && !stall_all
               && !redirect_valid && !stall_bot;

  always_comb begin
    pc_d     = pc_q;
    it_top_d = it_top_q;
    it_bot_d = it_bot_q;
    pc_top_d = pc_top_q;
    pc_bot_d = pc_bot_q;
    if (do_mp || do_rd) begin
      pc_d     = do_mp ? mispredict_pc
                       : redirect_pc;
      it_top_d = NOP;
      it_bot_d = NOP;
      pc_top_d = 32'h0;
      pc_bot_d = 32'h0;
    end else if (do_sb) begin
      // Unissued bottom slot moves up; bottom fetch is dropped
      it_top_d = it_bot_q;
      pc_top_d = pc_bot_q;
      it_bot_d = imem.imem_data_top;
      pc_bot_d = pc_q;
      pc_d     = pc_p1;
    end else if (do_nm) begin
      it_top_d = imem.imem_data_top;
      pc_top_d = pc_q;
      it_bot_d = imem.imem_data_bot;
      pc_bot_d = pc_p1;
      pc_d     = pc_q + 32'd2;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q     <= 32'h0;
      it_top_q <= NOP;
      it_bot_q <= NOP;
      pc_top_q <= 32'h0;
      pc_bot_q <= 32'h0;
    end else begin
      pc_q     <= pc_d;
      it_top_q <= it_top_d;
      it_bot_q <= it_bot_d;
      pc_top_q <= pc_top_d;
      pc_bot_q <= pc_bot_d;
    end
  end

  assign pc           = pc_q;
  assign fd_instr_top = it_top_q;
  assign fd_instr_bot = it_bot_q;
  assign fd_pc_top    = pc_top_q;
  assign fd_pc_bot    = pc_bot_q;

`ifdef FETCH_PERF_EN
  logic [31:0] issued_q, issued_d;
  logic [31:0] flushes_q, flushes_d;
  logic [32:0] issued_sum, flushes_sum;
  logic [1:0]  issued_inc;

  always_comb begin
    issued_inc = 2'd0;
    if (do_nm) issued_inc = 2'd2;
    else if (do_sb) issued_inc = 2'd1;
  end

  assign issued_sum  = {1'b0, issued_q}
                     + {31'h0, issued_inc};
  assign flushes_sum = {1'b0, flushes_q}
                     + {32'h0, do_mp | do_rd};

  always_comb begin
    issued_d  = issued_sum[32] ? 32'hFFFF_FFFF
                               : issued_sum[31:0];
    flushes_d = flushes_sum[32] ? 32'hFFFF_FFFF
                                : flushes_sum[31:0];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      issued_q  <= 32'h0;
      flushes_q <= 32'h0;
    end else begin
      issued_q  <= issued_d;
      flushes_q <= flushes_d;
    end
  end

  assign perf_issued  = issued_q;
  assign perf_flushes = flushes_q;
`endif

endmodule
